// File: rtl/udp_rx_parser.sv
// UDP receive parser: strips the 8-byte UDP header, filters on destination port,
// and forwards payload bytes with one-cycle end-of-frame / error markers.
module udp_rx_parser #(
    parameter logic [15:0] DEST_PORT = 16'h1234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ip_data_in,
    input  logic       ip_byte_valid,
    input  logic       ip_eof,
    input  logic       ip_err,
    output logic [7:0] udp_data_out,
    output logic       udp_byte_valid,
    output logic       udp_eof,
    output logic       udp_err
);

    typedef enum logic [1:0] {S_HEADER, S_PAYLOAD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [7:0]  dst_hi_q, dst_hi_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        eof_q, eof_d;
    logic        err_q, err_d;

    // Per-byte decision, shared by the next-state and output processes
    logic        ev_fwd, ev_eof, ev_err, ev_end, ev_drop;
    logic [15:0] dst_full, len_full, exp_cnt;

    assign dst_full = {dst_hi_q, ip_data_in};
    assign len_full = {len_q[15:8], ip_data_in};
    assign exp_cnt  = len_q - 16'd8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_HEADER;
            hdr_cnt_q <= '0;
            pay_cnt_q <= '0;
            dst_hi_q  <= '0;
            len_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            eof_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            dst_hi_q  <= dst_hi_d;
            len_q     <= len_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            eof_q     <= eof_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        ev_fwd  = 1'b0;
        ev_eof  = 1'b0;
        ev_err  = 1'b0;
        ev_end  = 1'b0;
        ev_drop = 1'b0;
        if (ip_byte_valid) begin
            if (ip_err) begin
                // Every entry into DROP has already reported this frame
                ev_err  = (state_q != S_DROP);
                ev_end  = ip_eof;
                ev_drop = !ip_eof;
            end else begin
                case (state_q)
                    S_HEADER: begin
                        if (ip_eof) begin
                            ev_end = 1'b1;
                            if (hdr_cnt_q == 3'd7 && len_q == 16'd8) ev_eof = 1'b1;
                            else                                     ev_err = 1'b1;
                        end else if (hdr_cnt_q == 3'd3 && dst_full != DEST_PORT) begin
                            ev_err  = 1'b1;
                            ev_drop = 1'b1;
                        end else if (hdr_cnt_q == 3'd5 && len_full < 16'd8) begin
                            ev_err  = 1'b1;
                            ev_drop = 1'b1;
                        end
                    end
                    S_PAYLOAD: begin
                        if (pay_cnt_q == exp_cnt) begin
                            ev_err  = 1'b1;
                            ev_end  = ip_eof;
                            ev_drop = !ip_eof;
                        end else begin
                            ev_fwd = 1'b1;
                            if (ip_eof) begin
                                ev_end = 1'b1;
                                if (pay_cnt_q + 16'd1 == exp_cnt) ev_eof = 1'b1;
                                else                              ev_err = 1'b1;
                            end
                        end
                    end
                    S_DROP:  ev_end = ip_eof;
                    default: ev_end = ip_eof;
                endcase
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        pay_cnt_d = pay_cnt_q;
        dst_hi_d  = dst_hi_q;
        len_d     = len_q;
        if (ip_byte_valid) begin
            if (ev_end) begin
                state_d   = S_HEADER;
                hdr_cnt_d = '0;
                pay_cnt_d = '0;
            end else if (ev_drop) begin
                state_d   = S_DROP;
                hdr_cnt_d = '0;
                pay_cnt_d = '0;
            end else begin
                case (state_q)
                    S_HEADER: begin
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                        case (hdr_cnt_q)
                            3'd2:    dst_hi_d = ip_data_in;
                            3'd4:    len_d[15:8] = ip_data_in;
                            3'd5:    len_d = len_full;
                            3'd7: begin
                                state_d   = S_PAYLOAD;
                                pay_cnt_d = '0;
                            end
                            default: ;
                        endcase
                    end
                    S_PAYLOAD: pay_cnt_d = pay_cnt_q + 16'd1;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        data_d  = ev_fwd ? ip_data_in : 8'h00;
        valid_d = ev_fwd;
        eof_d   = ev_eof;
        err_d   = ev_err;
    end

    assign udp_data_out   = data_q;
    assign udp_byte_valid = valid_q;
    assign udp_eof        = eof_q;
    assign udp_err        = err_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Lockstep bench for udp_rx_parser: frames are scored against a frame-level
// model of the UDP receive rules, one comparison per clock.
module tb_udp_rx_parser;

    localparam logic [15:0] DP = 16'h1234;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ip_data_in;
    logic       ip_byte_valid, ip_eof, ip_err;
    logic [7:0] udp_data_out;
    logic       udp_byte_valid, udp_eof, udp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_v, cnt_eof, cnt_err;

    logic [7:0]  f_data[$];
    bit          f_eof[$];
    bit          f_err[$];
    logic [10:0] x_out[$];

    udp_rx_parser #(.DEST_PORT(DP)) dut (
        .clk            (clk),
        .rst            (rst),
        .ip_data_in     (ip_data_in),
        .ip_byte_valid  (ip_byte_valid),
        .ip_eof         (ip_eof),
        .ip_err         (ip_err),
        .udp_data_out   (udp_data_out),
        .udp_byte_valid (udp_byte_valid),
        .udp_eof        (udp_eof),
        .udp_err        (udp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] dut_out();
        return {udp_byte_valid, udp_byte_valid ? udp_data_out : 8'h00, udp_eof, udp_err};
    endfunction

    // Packed as {valid, data, eof, err}
    task automatic step(input logic v, input logic [7:0] d, input logic e, input logic r,
                        input logic [10:0] exp, input string tag);
        ip_byte_valid = v;
        ip_data_in    = d;
        ip_eof        = e;
        ip_err        = r;
        @(posedge clk);
        #1;
        check(tag, 32'(dut_out()), 32'(exp));
        cnt_v   += int'(udp_byte_valid);
        cnt_eof += int'(udp_eof);
        cnt_err += int'(udp_err);
    endtask

    task automatic build(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                         input int npay, input int trunc, input int err_idx);
        logic [7:0] hdr[8];
        int total;
        hdr[0] = src[15:8]; hdr[1] = src[7:0];
        hdr[2] = dst[15:8]; hdr[3] = dst[7:0];
        hdr[4] = len[15:8]; hdr[5] = len[7:0];
        hdr[6] = 8'($urandom); hdr[7] = 8'($urandom);
        total = (trunc > 0) ? trunc : 8 + npay;
        f_data.delete(); f_eof.delete(); f_err.delete();
        for (int i = 0; i < total; i++) begin
            f_data.push_back(i < 8 ? hdr[i] : 8'($urandom));
            f_eof.push_back(i == total - 1);
            f_err.push_back(i == err_idx);
        end
    endtask

    // Expected output for each input byte, from the frame-level rules
    task automatic model();
        int n, p, expn;
        bit done;
        logic [15:0] dst, len;
        logic [10:0] o;
        n = f_data.size();
        done = 1'b0;
        dst = (n >= 4) ? {f_data[2], f_data[3]} : 16'h0;
        len = (n >= 6) ? {f_data[4], f_data[5]} : 16'h0;
        expn = int'(len) - 8;
        x_out.delete();
        for (int i = 0; i < n; i++) begin
            o = '0;
            if (f_err[i]) begin
                if (!done) o[0] = 1'b1;
                done = 1'b1;
            end else if (!done) begin
                if (i < 8) begin
                    if (f_eof[i]) begin
                        if (i == 7 && len == 16'd8) o[1] = 1'b1;
                        else                        o[0] = 1'b1;
                        done = 1'b1;
                    end else if ((i == 3 && dst != DP) || (i == 5 && len < 16'd8)) begin
                        o[0] = 1'b1;
                        done = 1'b1;
                    end
                end else begin
                    p = i - 8;
                    if (p >= expn) begin
                        o[0] = 1'b1;
                        done = 1'b1;
                    end else begin
                        o[10]  = 1'b1;
                        o[9:2] = f_data[i];
                        if (f_eof[i]) begin
                            if (p + 1 == expn) o[1] = 1'b1;
                            else               o[0] = 1'b1;
                            done = 1'b1;
                        end
                    end
                end
            end
            x_out.push_back(o);
        end
    endtask

    // Drives up to 'limit' bytes of the current frame (all if limit < 0)
    task automatic send(input int max_gap, input string tag, input int limit);
        int n;
        model();
        cnt_v = 0; cnt_eof = 0; cnt_err = 0;
        n = (limit < 0) ? f_data.size() : limit;
        for (int i = 0; i < n; i++) begin
            step(1'b1, f_data[i], f_eof[i], f_err[i], x_out[i], $sformatf("%s_b%0d", tag, i));
            for (int g = $urandom_range(0, max_gap); g > 0; g--)
                step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 11'h0,
                     $sformatf("%s_idle%0d", tag, i));
        end
    endtask

    initial begin
        int kind, npay, trunc, erri, total;
        logic [15:0] dst, len;
        rst = 1'b1;
        ip_byte_valid = 1'b0; ip_data_in = '0; ip_eof = 1'b0; ip_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 32'(dut_out()), 32'h0);
        rst = 1'b0;

        build(16'hAAAA, DP, 16'd28, 20, 0, -1);
        send(4, "valid", -1);
        check("valid_nbytes", cnt_v, 20);
        check("valid_neof", cnt_eof, 1);
        check("valid_nerr", cnt_err, 0);

        build(16'hAAAA, 16'h5555, 16'd28, 20, 0, -1);
        send(2, "badport", -1);
        check("badport_nbytes", cnt_v, 0);
        check("badport_nerr", cnt_err, 1);

        build(16'hAAAA, DP, 16'd28, 20, 0, 27);
        send(1, "iperr", -1);
        check("iperr_nbytes", cnt_v, 19);
        check("iperr_nerr", cnt_err, 1);
        check("iperr_neof", cnt_eof, 0);

        build(16'hAAAA, DP, 16'd28, 10, 0, -1);
        send(1, "short", -1);
        check("short_nbytes", cnt_v, 10);
        check("short_nerr", cnt_err, 1);
        build(16'h0101, DP, 16'd13, 5, 0, -1);
        send(1, "after_short", -1);
        check("after_short_neof", cnt_eof, 1);

        build(16'hAAAA, DP, 16'd8, 0, 0, -1);
        send(2, "empty", -1);
        check("empty_neof", cnt_eof, 1);
        check("empty_nbytes", cnt_v, 0);

        build(16'hBEEF, DP, 16'd48, 40, 0, -1);
        send(0, "b2b", 20);
        rst = 1'b1;
        #1;
        check("rst_async_clear", 32'(dut_out()), 32'h0);
        ip_byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_held", 32'(dut_out()), 32'h0);
        rst = 1'b0;
        build(16'hBEEF, DP, 16'd40, 32, 0, -1);
        send(0, "post_rst", -1);
        check("post_rst_nbytes", cnt_v, 32);
        check("post_rst_neof", cnt_eof, 1);

        for (int f = 0; f < 250; f++) begin
            kind  = $urandom_range(0, 6);
            npay  = $urandom_range(0, 24);
            dst   = DP;
            len   = 16'(8 + npay);
            trunc = 0;
            erri  = -1;
            case (kind)
                1: dst = DP ^ (16'h1 << $urandom_range(0, 15));
                3: len = 16'(8 + $urandom_range(0, 30));
                4: len = 16'($urandom_range(0, 7));
                5: trunc = $urandom_range(1, 7);
                6: len = 16'(8 + $urandom_range(0, 30));
                default: ;
            endcase
            total = (trunc > 0) ? trunc : 8 + npay;
            if (kind == 2 || kind == 6) erri = $urandom_range(0, total - 1);
            build(16'($urandom), dst, len, npay, trunc, erri);
            send(2, $sformatf("rnd%0d_k%0d", f, kind), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
